ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM (write-enable, address, write data, registered read data) between NUM_REQ requesters.
- Round-robin grant with a valid/ready request handshake. At most one access is issued per cycle.
- Registers the winning command onto the RAM ports and routes read data back to the originating requester with a fixed latency.
- Sits between client blocks and the RAM instance; no RAM storage inside.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width (2^ADDR_WIDTH words).
- NUM_REQ, 4, number of requesters (>=2).

Ports:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero, combinational.
- req_we  in  NUM_REQ  per-requester command type, 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, sliced the same way.
- ram_we  out  1  registered RAM write enable.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM registered read data.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe, registered.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters; valid where rsp_valid is set.
- idle  out  1  high when no command is in flight and req_valid==0.

Behaviour:
- Reset (async, rst=1): ram_we=0, ram_addr=0, ram_wdata=0, rsp_valid=0, rr pointer=0, all in-flight tracking cleared. req_ready is 0 while rst=1.
- Grant:
  - Among asserted req_valid bits, pick the first index at or after the rr pointer, wrapping modulo NUM_REQ.
  - req_ready[winner]=1; all others 0.
  - A handshake occurs at posedge when valid&&ready. After a handshake by requester i, the pointer becomes (i+1) mod NUM_REQ. With no handshake, the pointer holds.
  - A requester must hold valid and payload stable until ready. Dropping valid before grant is permitted and is not an error.
- Pipeline, handshake at edge T:
  - Cycle T+1: ram_we/addr/wdata present the command. The RAM samples it at the end of T+1.
  - Cycle T+2: for reads, rsp_valid[i]=1 and rsp_rdata=ram_rdata.
  - Read latency is exactly 2 cycles. Writes produce no response.
  - Idle cycles drive ram_we=0; ram_addr and ram_wdata hold their last values.
- Throughput: one handshake per cycle, sustained. A lone requester is granted every cycle.
- The response path has no backpressure; requesters must accept rsp_valid unconditionally.
- Ordering:
  - Accesses reach the RAM in grant order.
  - Write at T followed by a read of the same address at T+1 returns the new data.
  - A read and a write cannot issue in the same cycle.
- Tracking: a 2-stage shift of {valid, is_read, requester index}. Stage 2 drives rsp_valid.
- Reset mid-operation:
  - In-flight reads are dropped; no rsp_valid after reset.
  - A write registered but not yet sampled by the RAM is cancelled (ram_we forced 0).
- NUM_REQ must be >= 2. Width of the index is $clog2(NUM_REQ).

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest asserted index wins; the rr pointer is removed.
- Undefined (default): round-robin as above.
- Pipeline, latency and reset behaviour are identical in both modes.

Decomposition:
- Package ram_arb_pkg:
  - Default width constants.
  - Typedef for the tracking-stage struct {valid, is_read, idx}.
  - Function computing the next rr pointer.
- Sub-module rr_arbiter: NUM_REQ-wide request vector and advance strobe in, one-hot grant out. It owns the pointer register (async reset to 0) and honours RAM_ARB_FIXED_PRIO_EN.
- ram_arbiter owns the mux, command registers and tracking pipeline.

Test Plan:
- Reset: assert rst mid-burst with a read in flight -> ram_we=0, rsp_valid=0 at the next cycle and thereafter; pointer=0; first grant after release goes to lowest valid index.
- Single requester: req 0 writes 0xA5 to addr 3 at T, reads addr 3 at T+1 -> ram_we=1/addr 3 in T+1; rsp_valid=4'b0001, rsp_rdata=0xA5 at T+3.
- Round-robin fairness: all four valid continuously, reads only -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_valid follows the same order, 2 cycles later.
- Pointer wrap and skip: pointer=3, only reqs 1 and 2 valid -> grant 1, then 2, then 1.
- Hold/stability: req 2 valid but not granted for 3 cycles with payload held -> exactly one access to its address, one rsp_valid[2] pulse.
- RAM_ARB_FIXED_PRIO_EN defined: reqs 0 and 3 continuously valid -> req 0 granted every cycle, req_ready[3] never asserted.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Purpose: shared widths, tracking-stage type and round-robin pointer helper for ram_arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_REQ    = 4;

    // Requester index field in the tracking stages is sized for the largest
    // requester count we expect to build; the live index is zero-extended into it.
    localparam int IDX_W_MAX      = 8;

    // One slot of the read-return tracking pipeline.
    typedef struct packed {
        logic                 valid;
        logic                 is_read;
        logic [IDX_W_MAX-1:0] idx;
    } trk_t;

    // Pointer moves to the slot just after the winner, wrapping after the last requester.
    function automatic logic [IDX_W_MAX-1:0] rr_next_ptr(
        input logic [IDX_W_MAX-1:0] winner,
        input logic [IDX_W_MAX-1:0] last_idx
    );
        return (winner == last_idx) ? '0 : winner + IDX_W_MAX'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: one-hot grant among NUM_REQ requests; round-robin, or fixed priority with RAM_ARB_FIXED_PRIO_EN.
// Latency: grant is combinational from req; pointer updates on the edge where advance is high.
// Backpressure: none; advance tells the arbiter the granted request was accepted.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             any_req;
    logic [IDX_W-1:0] idx_lo;

    // Lowest asserted request index; scanned downward so the lowest one is written last.
    always_comb begin
        any_req = 1'b0;
        idx_lo  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                idx_lo  = IDX_W'(i);
            end
        end
    end

`ifdef RAM_ARB_FIXED_PRIO_EN

    // Fixed priority keeps no state, so the clock, reset and advance strobe go unused.
    logic unused_fixed_prio;
    assign unused_fixed_prio = ^{clk, rst, advance};
    assign grant_idx         = idx_lo;

`else

    logic [IDX_W-1:0] ptr;
    logic             found_hi;
    logic [IDX_W-1:0] idx_hi;

    // Lowest asserted request at or above the pointer; if none, wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                idx_hi   = IDX_W'(i);
            end
        end
    end

    assign grant_idx = found_hi ? idx_hi : idx_lo;

    // Pointer follows the last accepted winner; it holds while nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && any_req) begin
            ptr <= IDX_W'(rr_next_ptr(IDX_W_MAX'(grant_idx), IDX_W_MAX'(NUM_REQ - 1)));
        end
    end

`endif

    // Decode the winning index to a one-hot grant, zero when nobody requests.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any_req && (grant_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Purpose: shares one single-port sync RAM between NUM_REQ requesters (RAM_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: command on RAM pins 1 cycle after handshake; read response 2 cycles after handshake.
// Backpressure: valid/ready per requester, one grant per cycle; response path has no backpressure.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    input  logic [DATA_WIDTH-1:0]          ram_rdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           idle
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  fire;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    trk_t                  trk_in;
    trk_t                  trk_s1;
    trk_t                  trk_s2;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (fire),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // No grants while reset is held; grant is already qualified by req_valid,
    // so any ready bit means a handshake at the coming edge.
    assign req_ready = rst ? '0 : grant;
    assign fire      = |req_ready;

    // Select the winning requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Command register: write enable pulses only for accepted writes; address and
    // data hold between commands so idle cycles do not toggle the RAM pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_we <= fire && sel_we;
            if (fire) begin
                ram_addr <= sel_addr;
            end
            if (fire && sel_we) begin
                ram_wdata <= sel_wdata;
            end
        end
    end

    // Tracking entry for the command being accepted this cycle.
    always_comb begin
        trk_in         = '0;
        trk_in.valid   = fire;
        trk_in.is_read = fire && !sel_we;
        trk_in.idx     = IDX_W_MAX'(grant_idx);
    end

    // Two-stage tracking shift: stage 1 lines up with the RAM command, stage 2 with read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_s1 <= '0;
            trk_s2 <= '0;
        end else begin
            trk_s1 <= trk_in;
            trk_s2 <= trk_s1;
        end
    end

    // Steer the response strobe to the requester recorded in stage 2 (reads only).
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = trk_s2.valid && trk_s2.is_read && (trk_s2.idx == IDX_W_MAX'(i));
        end
    end

    // RAM read data is already registered; share it with every requester.
    assign rsp_rdata = ram_rdata;

    assign idle = !(|req_valid) && !trk_s1.valid && !trk_s2.valid;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              idle;

    ram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered read data.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_exp_t;

    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] data;
    } rsp_exp_t;

    cmd_exp_t      cmdq[$];
    rsp_exp_t      rspq[$];

    logic [NR-1:0] v;
    logic [NR-1:0] w;
    logic [NR-1:0] oneshot;
    logic [AW-1:0] a [NR];
    logic [DW-1:0] d [NR];
    logic [DW-1:0] mem_m [16];
    int            cnt [NR];
    int            ptr;
    int            cyc;
    bit            hs1, hs2;
    int            last_grant;
    int            n_checks;
    int            n_pass;
    int            n_fail;
    int            exp_seq [6];
    int            req2_before;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference arbitration: first valid index at or after the pointer, wrapping.
    function automatic int model_grant(input logic [NR-1:0] vv, input int p);
        int idx;
        for (int k = 0; k < NR; k++) begin
            idx = (p + k) % NR;
            if (vv[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = v;
        req_we    = w;
        for (int r = 0; r < NR; r++) begin
            req_addr[r*AW +: AW]  = a[r];
            req_wdata[r*DW +: DW] = d[r];
        end
    endtask

    // One clock cycle: drive, check grant/idle, score the handshake, then check registered outputs.
    task automatic step();
        int            g;
        logic [NR-1:0] exp_rdy;
        cmd_exp_t      c;
        rsp_exp_t      e;
        drive();
        #1;
        g = rst ? -1 : model_grant(v, ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy = NR'(1) << g;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("idle", 32'(idle), 32'((v == '0) && !hs1 && !hs2));
        if (g >= 0) begin
            c.cyc = cyc + 1; c.we = w[g]; c.addr = a[g]; c.data = d[g];
            cmdq.push_back(c);
            if (w[g]) begin
                mem_m[a[g]] = d[g];
            end else begin
                e.cyc = cyc + 2; e.idx = g; e.data = mem_m[a[g]];
                rspq.push_back(e);
            end
`ifndef RAM_ARB_FIXED_PRIO_EN
            ptr = (g + 1) % NR;
`endif
            cnt[g]++;
        end
        hs2 = hs1;
        hs1 = (g >= 0);
        last_grant = g;
        @(posedge clk);
        cyc++;
        if (g >= 0 && oneshot[g]) v[g] = 1'b0;
        @(negedge clk);
        if (cmdq.size() > 0 && cmdq[0].cyc == cyc) begin
            c = cmdq.pop_front();
            check("ram_we", 32'(ram_we), 32'(c.we));
            check("ram_addr", 32'(ram_addr), 32'(c.addr));
            if (c.we) check("ram_wdata", 32'(ram_wdata), 32'(c.data));
        end else begin
            check("ram_we_idle", 32'(ram_we), 32'(0));
        end
        if (rspq.size() > 0 && rspq[0].cyc == cyc) begin
            e = rspq.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(NR'(1) << e.idx));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
        end
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        cmdq.delete();
        rspq.delete();
        ptr = 0;
        hs1 = 1'b0;
        hs2 = 1'b0;
        #1;
        check("rst_ram_we", 32'(ram_we), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
    endtask

    // Continuous requesters present a new address each time they are granted.
    task automatic load_reads();
        for (int r = 0; r < NR; r++) begin
            a[r] = AW'(r * 4 + cnt[r]);
            w[r] = 1'b0;
        end
    endtask

    initial begin
        v = '0; w = '0; oneshot = '0;
        for (int r = 0; r < NR; r++) begin a[r] = '0; d[r] = '0; cnt[r] = 0; end
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        ptr = 0; cyc = 0; hs1 = 0; hs2 = 0; last_grant = -1;
        n_checks = 0; n_pass = 0; n_fail = 0;
        drive();

        // Reset state, including no grant while reset is held.
        #2;
        assert_reset();
        check("rst_ram_addr", 32'(ram_addr), 32'(0));
        check("rst_ram_wdata", 32'(ram_wdata), 32'(0));
        @(negedge clk);
        v = 4'b1111;
        step();
        step();
        v = '0;
        step();

        // Single requester: write 0xA5 to addr 3, then read it back the next cycle.
        rst = 1'b0;
        v = 4'b0001; w = 4'b0001; a[0] = 4'd3; d[0] = 8'hA5;
        step();
        check("single_wr_grant", 32'(last_grant), 32'(0));
        w[0] = 1'b0;
        step();
        check("single_rd_grant", 32'(last_grant), 32'(0));
        v = '0;
        repeat (3) step();

        // Lone requester 3 fills every word, granted back to back.
        v = 4'b1000; w = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            a[3] = AW'(i);
            d[3] = DW'(8'h40 + i);
            step();
            check("fill_grant", 32'(last_grant), 32'(3));
        end
        v = '0; w = '0;
        step();

        // All four reading continuously.
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1};
`endif
        v = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            load_reads();
            step();
            check("fair_grant", 32'(last_grant), 32'(exp_seq[k]));
        end
        v = '0;
        step();

        // Pointer wrap and skip: bring pointer to 3, then only 1 and 2 request.
        load_reads(); v = 4'b0100;
        step();
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_seq = '{1, 1, 1, 0, 0, 0};
`else
        exp_seq = '{1, 2, 1, 0, 0, 0};
`endif
        v = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            load_reads();
            step();
            check("wrap_grant", 32'(last_grant), 32'(exp_seq[k]));
        end
        v = '0;
        step();

        // Hold: requester 2 waits with its payload held; each requester issues once.
        load_reads(); v = 4'b0100;
        step();
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 1, 2, 3, 0, 0};
`else
        exp_seq = '{3, 0, 1, 2, 0, 0};
`endif
        oneshot = 4'b1111; v = 4'b1111; w = '0;
        a[0] = 4'd5; a[1] = 4'd6; a[2] = 4'd14; a[3] = 4'd7;
        req2_before = cnt[2];
        for (int k = 0; k < 4; k++) begin
            step();
            check("hold_grant", 32'(last_grant), 32'(exp_seq[k]));
        end
        repeat (3) step();
        check("hold_req2_once", 32'(cnt[2] - req2_before), 32'(1));
        oneshot = '0;

        // Requesters 0 and 3 both continuously valid.
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0, 0};
`else
        exp_seq = '{3, 0, 3, 0, 0, 0};
`endif
        v = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            load_reads();
            step();
            check("pair_grant", 32'(last_grant), 32'(exp_seq[k]));
        end
        v = '0;
        step();

        // Reset mid-burst with reads in flight; first grant afterwards is the lowest valid index.
        v = 4'b1111;
        load_reads(); step();
        load_reads(); step();
        assert_reset();
        step();
        step();
        rst = 1'b0;
        load_reads(); v = 4'b1100;
        step();
        check("post_rst_grant", 32'(last_grant), 32'(2));
        v = '0;
        repeat (3) step();

        check("drain_cmd", 32'(cmdq.size()), 32'(0));
        check("drain_rsp", 32'(rspq.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
